// File: rtl/imem_loader_pkg.sv
// Shared state encoding and widths for the instruction-memory loader and the core's instruction memory.
// The CHK state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   localparam int IMEM_ADDR_W = 12;
   localparam int IMEM_WORD_W = 16;

   typedef enum logic [3:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
      CHK,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Pairs stream bytes into big-endian instruction words and flags each completed word for one cycle.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of every data byte.
module byte_pair_assembler
   import imem_loader_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load_hi,
   input  logic                   load_lo,
   input  logic [7:0]             byte_data,
   output logic [IMEM_WORD_W-1:0] word,
   output logic                   word_ready
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]             xor_sum
`endif
);

   logic [7:0] hi_byte;

   // The word register only changes when a low byte lands, so it stays stable between writes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hi_byte    <= '0;
         word       <= '0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= load_lo;
         if (clear) begin
            hi_byte <= '0;
         end else if (load_hi) begin
            hi_byte <= byte_data;
         end
         if (load_lo) begin
            word <= {hi_byte, byte_data};
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         xor_sum <= '0;
      end else if (clear) begin
         xor_sum <= '0;
      end else if (load_hi || load_lo) begin
         xor_sum <= xor_sum ^ byte_data;
      end
   end
`endif

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, holding the core until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the core.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int WORD_W    = IMEM_WORD_W,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   state_t                 state, next_state;
   logic [15:0]            length;
   logic [ADDR_W-1:0]      word_cnt;
   logic [15:0]            hdr_len;
   logic [IMEM_WORD_W-1:0] word;
   logic                   xfer, start_ok, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]             xor_sum;
`endif

   assign xfer       = byte_valid && byte_ready;
   assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
   assign hdr_len    = {length[15:8], byte_data};
   assign last_word  = (32'(word_cnt) == (32'(length) - 32'd1));
   assign imem_wdata = word;
   assign cpu_hold   = (state != DONE);
   assign done       = (state == DONE);
   assign error      = (state == ERROR);

   byte_pair_assembler u_assembler (
      .clock      (clock),
      .reset      (reset),
      .clear      (start_ok),
      .load_hi    (xfer && (state == DAT_HI)),
      .load_lo    (xfer && (state == DAT_LO)),
      .byte_data  (byte_data),
      .word       (word),
      .word_ready (imem_we)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .xor_sum    (xor_sum)
`endif
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; byte_ready is asserted only in the byte-consuming states.
   always_comb begin
      next_state = state;
      byte_ready = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) next_state = HDR_HI;
         end
         HDR_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) next_state = HDR_LO;
         end
         HDR_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (32'(hdr_len) > 32'(MAX_WORDS)) begin
                  next_state = ERROR;
               end else if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  next_state = CHK;
`else
                  next_state = DONE;
`endif
               end else begin
                  next_state = DAT_HI;
               end
            end
         end
         DAT_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) next_state = DAT_LO;
         end
         DAT_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) next_state = WRITE;
         end
         WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               next_state = CHK;
`else
               next_state = DONE;
`endif
            end else begin
               next_state = DAT_HI;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: begin
            byte_ready = 1'b1;
            if (byte_valid) next_state = (byte_data == xor_sum) ? DONE : ERROR;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Header capture, word counter and write address; the address is set on the edge that enters WRITE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         length    <= '0;
         word_cnt  <= '0;
         imem_addr <= '0;
      end else begin
         if (start_ok) begin
            word_cnt <= '0;
         end else if ((state == WRITE) && !last_word) begin
            word_cnt <= word_cnt + ADDR_W'(1);
         end
         if (xfer && (state == HDR_HI)) length[15:8] <= byte_data;
         if (xfer && (state == HDR_LO)) length[7:0]  <= byte_data;
         if (xfer && (state == DAT_LO)) imem_addr    <= word_cnt;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load sessions with a write scoreboard, plus a reset-mid-load sequence.
// Define IMEM_LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum byte.
module tb_imem_loader;
   import imem_loader_pkg::*;

   typedef struct {
      logic [15:0]      len;
      int               nwords;
      logic [2:0][15:0] words;
      int               stall;
      logic [7:0]       chk_flip;
   } case_t;

   typedef struct packed {
      logic [11:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, imem_we, cpu_hold, done, error;
   logic [11:0] imem_addr;
   logic [15:0] imem_wdata;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int last_we_cycle = -1;
   int write_count = 0;
   wr_t exp_q[$];
   case_t cases[$];

   imem_loader dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clock) begin
      if (reset && imem_we) begin
         wr_t e;
         last_we_cycle = cycle;
         write_count++;
         if (exp_q.size() == 0) begin
            check_output("extra_write", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_output("write_addr", 32'(imem_addr), 32'(e.addr));
            check_output("write_data", 32'(imem_wdata), 32'(e.data));
         end
      end
   end

   function automatic case_t mk(input logic [15:0] len, input int n, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2, input int stall,
                                input logic [7:0] flip);
      case_t c;
      c.len = len;
      c.nwords = n;
      c.words = {w2, w1, w0};
      c.stall = stall;
      c.chk_flip = flip;
      return c;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data = b;
      while (!byte_ready && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (!byte_ready) check_output("ready_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
   endtask

   // Holds valid low for n cycles and pulses start once, which must be ignored mid-load.
   task automatic stall_with_start(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         start = (k == 1);
         check_output("ready_in_stall", 32'(byte_ready), 32'd1);
      end
      start = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(done || error) && n < 20);
      if (!(done || error)) check_output("end_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_session();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_output("hold_after_start", 32'(cpu_hold), 32'd1);
      check_output("done_after_start", 32'(done), 32'd0);
      check_output("error_after_start", 32'(error), 32'd0);
   endtask

   task automatic apply_stimulus(input case_t c);
      logic [7:0]  x = 8'h00;
      logic [15:0] w;
      logic        exp_err;
      int          writes_before = write_count;
      int          exp_writes = 0;
      exp_err = (c.len > 16'd4096);
      start_session();
      send_byte(c.len[15:8]);
      send_byte(c.len[7:0]);
      if (!exp_err) begin
         for (int i = 0; i < c.nwords; i++) begin
            w = c.words[i];
            x = x ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            if (i == 0 && c.stall > 0) stall_with_start(c.stall);
            exp_q.push_back('{addr: 12'(i), data: w});
            send_byte(w[7:0]);
         end
         exp_writes = c.nwords;
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(x ^ c.chk_flip);
         exp_err = (c.chk_flip != 8'h00);
`endif
      end
      wait_end();
      check_output("done", 32'(done), 32'(!exp_err));
      check_output("error", 32'(error), 32'(exp_err));
      check_output("cpu_hold", 32'(cpu_hold), 32'(exp_err));
      check_output("write_count", 32'(write_count - writes_before), 32'(exp_writes));
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (!exp_err && c.nwords > 0) check_output("done_latency", 32'(cycle - last_we_cycle), 32'd1);
`endif
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_we"}, 32'(imem_we), 32'd0);
      check_output({tag, "_addr"}, 32'(imem_addr), 32'd0);
      check_output({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
      check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
      check_output({tag, "_done"}, 32'(done), 32'd0);
      check_output({tag, "_error"}, 32'(error), 32'd0);
      check_output({tag, "_hold"}, 32'(cpu_hold), 32'd1);
   endtask

   initial begin
      cases.push_back(mk(16'h0002, 2, 16'h1234, 16'hABCD, 16'h0000, 0, 8'h00));
      cases.push_back(mk(16'h0002, 2, 16'h1234, 16'hABCD, 16'h0000, 5, 8'h00));
      cases.push_back(mk(16'h1001, 0, 16'h0000, 16'h0000, 16'h0000, 0, 8'h00));
      cases.push_back(mk(16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 8'h00));
      cases.push_back(mk(16'h0003, 3, 16'h0001, 16'h8000, 16'hFFFF, 0, 8'h00));
      cases.push_back(mk(16'h0001, 1, 16'hF00F, 16'h0000, 16'h0000, 0, 8'h00));
`ifdef IMEM_LOADER_CHECKSUM_EN
      cases.push_back(mk(16'h0001, 1, 16'hF00F, 16'h0000, 16'h0000, 0, 8'h01));
      cases.push_back(mk(16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 8'h01));
`endif

      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b1;

      foreach (cases[i]) apply_stimulus(cases[i]);

      // Reset while the low byte of the third word is awaited, then reload from address 0.
      start_session();
      send_byte(8'h00);
      send_byte(8'h03);
      exp_q.push_back('{addr: 12'd0, data: 16'h1111});
      send_byte(8'h11);
      send_byte(8'h11);
      exp_q.push_back('{addr: 12'd1, data: 16'h2222});
      send_byte(8'h22);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clock);
      #2 reset = 1'b0;
      #1 check_reset_values("midload");
      check_output("midload_pending", 32'(exp_q.size()), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      apply_stimulus(mk(16'h0003, 3, 16'hCAFE, 16'hBEEF, 16'h0F0F, 0, 8'h00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
